// File: rtl/pc_pkg.sv
// pc_pkg: shared definitions for the program-counter unit.
//   - pc_sel_t / SEL_*  : next-PC select encoding
//   - DEF_PC_W/DEF_OFF_W: default PC and offset-field widths
package pc_pkg;

  localparam int DEF_PC_W  = 32;
  localparam int DEF_OFF_W = 8;

  typedef logic [1:0] pc_sel_t;

  localparam pc_sel_t SEL_SEQ  = 2'd0;  // PC + INC
  localparam pc_sel_t SEL_TGT  = 2'd1;  // PC-relative target
  localparam pc_sel_t SEL_RAS  = 2'd2;  // top of return-address stack
  localparam pc_sel_t SEL_HOLD = 2'd3;  // keep current PC

endpackage

// File: rtl/pc_unit_if.sv
// pc_unit_if: control-unit <-> PC-unit bus.
//   Requests (master -> slave): STALL, BRANCH, JUMP, CALL, RET, OFFSET
//   Status   (slave -> master): PC, PC_PLUS, TARGET, RAS_EMPTY, RAS_FULL, RAS_ERR
interface pc_unit_if #(
  parameter int PC_W  = pc_pkg::DEF_PC_W,
  parameter int OFF_W = pc_pkg::DEF_OFF_W
);
  logic             STALL;
  logic             BRANCH;
  logic             JUMP;
  logic             CALL;
  logic             RET;
  logic [OFF_W-1:0] OFFSET;
  logic [PC_W-1:0]  PC;
  logic [PC_W-1:0]  PC_PLUS;
  logic [PC_W-1:0]  TARGET;
  logic             RAS_EMPTY;
  logic             RAS_FULL;
  logic             RAS_ERR;

  modport master (
    output STALL, BRANCH, JUMP, CALL, RET, OFFSET,
    input  PC, PC_PLUS, TARGET, RAS_EMPTY, RAS_FULL, RAS_ERR
  );

  modport slave (
    input  STALL, BRANCH, JUMP, CALL, RET, OFFSET,
    output PC, PC_PLUS, TARGET, RAS_EMPTY, RAS_FULL, RAS_ERR
  );
endinterface

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack.
//   clk_i, rst_ni (sync, active-low)
//   push_i/push_data_i : push a return address (overwrites oldest when full)
//   pop_i              : pop top entry (pop on empty only flags an error)
//   top_o              : current top entry (valid when !empty_o)
//   empty_o/full_o     : derived from registered count
//   err_o              : sticky over/underflow flag, cleared only by reset
// pop_i has priority over push_i if both are asserted.
module pc_ras #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] push_data_i,
  output logic [W-1:0] top_o,
  output logic         empty_o,
  output logic         full_o,
  output logic         err_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wp_q, wp_d;     // next write slot; top is wp_q-1
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign err_o   = err_q;
  assign top_o   = mem_q[wp_q - PW'(1)];

  always_comb begin
    wp_d  = wp_q;
    cnt_d = cnt_q;
    err_d = err_q;
    if (pop_i) begin
      if (empty_o) begin
        err_d = 1'b1;
      end else begin
        wp_d  = wp_q - PW'(1);
        cnt_d = cnt_q - CW'(1);
      end
    end else if (push_i) begin
      // DEPTH is a power of two, so the pointer wraps onto the oldest
      // entry once full; count saturates and the loss is flagged.
      wp_d = wp_q + PW'(1);
      if (full_o) err_d = 1'b1;
      else        cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wp_q  <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      wp_q  <= wp_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  // Storage has no reset; contents are meaningless while count is zero.
  always_ff @(posedge clk_i) begin
    if (rst_ni && push_i && !pop_i) mem_q[wp_q] <= push_data_i;
  end
endmodule

// File: rtl/pc_unit.sv
// pc_unit: PC register, sequential/target adders, next-PC select and RAS.
//   CLK   : rising-edge clock
//   RESET : synchronous active-low reset (PC <= RESET_PC, stack emptied)
//   bus   : pc_unit_if.slave (requests in, PC/PC_PLUS/TARGET/RAS flags out)
// Priority: reset > STALL > RET > CALL > JUMP|BRANCH > sequential.
module pc_unit
  import pc_pkg::*;
#(
  parameter int              PC_W      = DEF_PC_W,
  parameter int unsigned     INC       = 4,
  parameter int              OFF_W     = DEF_OFF_W,
  parameter int              OFF_SHIFT = 2,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter int              RAS_DEPTH = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  pc_unit_if.slave   bus
);
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pc_plus, target, off_sext, ras_top;
  logic            ras_push, ras_pop, ras_empty, ras_full, ras_err;
  pc_sel_t         sel;

  // Sign-extend first, then scale words to bytes; sums wrap mod 2^PC_W.
  assign off_sext = {{(PC_W-OFF_W){bus.OFFSET[OFF_W-1]}}, bus.OFFSET};
  assign pc_plus  = pc_q + PC_W'(INC);
  assign target   = pc_plus + (off_sext << OFF_SHIFT);

  always_comb begin
    sel      = SEL_SEQ;
    ras_push = 1'b0;
    ras_pop  = 1'b0;
    if (bus.STALL) begin
      sel = SEL_HOLD;
    end else if (bus.RET) begin
      // Pop on empty only raises the error; fall through to sequential.
      ras_pop = 1'b1;
      sel     = ras_empty ? SEL_SEQ : SEL_RAS;
    end else if (bus.CALL) begin
      ras_push = 1'b1;
      sel      = SEL_TGT;
    end else if (bus.JUMP || bus.BRANCH) begin
      sel = SEL_TGT;
    end
  end

  always_comb begin
    case (sel)
      SEL_TGT:  pc_d = target;
      SEL_RAS:  pc_d = ras_top;
      SEL_HOLD: pc_d = pc_q;
      default:  pc_d = pc_plus;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end

  pc_ras #(
    .W     (PC_W),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk_i       (CLK),
    .rst_ni      (RESET),
    .push_i      (ras_push),
    .pop_i       (ras_pop),
    .push_data_i (pc_plus),
    .top_o       (ras_top),
    .empty_o     (ras_empty),
    .full_o      (ras_full),
    .err_o       (ras_err)
  );

  assign bus.PC        = pc_q;
  assign bus.PC_PLUS   = pc_plus;
  assign bus.TARGET    = target;
  assign bus.RAS_EMPTY = ras_empty;
  assign bus.RAS_FULL  = ras_full;
  assign bus.RAS_ERR   = ras_err;
endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;
  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  pc_unit_if #(.PC_W(32), .OFF_W(8)) bus ();

  pc_unit #(
    .PC_W(32), .INC(4), .OFF_W(8), .OFF_SHIFT(2), .RESET_PC(32'h0), .RAS_DEPTH(4)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] pc;
    logic        empty;
    logic        full;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_pc;
  logic [31:0] m_stk[$];
  logic        m_err;
  int          n_chk = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] m_tgt(input logic [31:0] pc, input logic [7:0] off);
    logic [31:0] s;
    s = {{24{off[7]}}, off};
    return pc + 32'd4 + (s << 2);
  endfunction

  // Drive one cycle of requests, advance the reference model, push its
  // expectation, then pop and compare once the DUT has clocked.
  task automatic step(input logic rst, stl, br, jmp, cal, rt, input logic [7:0] off);
    exp_t e, got;
    logic [31:0] ppl;
    RESET = rst; bus.STALL = stl; bus.BRANCH = br; bus.JUMP = jmp;
    bus.CALL = cal; bus.RET = rt; bus.OFFSET = off;
    ppl = m_pc + 32'd4;
    if (!rst) begin
      m_pc = 32'h0; m_stk.delete(); m_err = 1'b0;
    end else if (stl) begin
      m_pc = m_pc;
    end else if (rt) begin
      if (m_stk.size() > 0) m_pc = m_stk.pop_back();
      else begin m_pc = ppl; m_err = 1'b1; end
    end else if (cal) begin
      if (m_stk.size() == 4) begin void'(m_stk.pop_front()); m_err = 1'b1; end
      m_stk.push_back(ppl);
      m_pc = m_tgt(m_pc, off);
    end else if (br || jmp) begin
      m_pc = m_tgt(m_pc, off);
    end else begin
      m_pc = ppl;
    end
    e.pc = m_pc; e.empty = (m_stk.size() == 0); e.full = (m_stk.size() == 4); e.err = m_err;
    sb.push_back(e);
    @(posedge CLK);
    #1;
    if (sb.size() == 0) begin
      chk("sb_underrun", 32'd0, 32'd1);
    end else begin
      got = sb.pop_front();
      chk("pc",    bus.PC,               got.pc);
      chk("empty", {31'd0, bus.RAS_EMPTY}, {31'd0, got.empty});
      chk("full",  {31'd0, bus.RAS_FULL},  {31'd0, got.full});
      chk("err",   {31'd0, bus.RAS_ERR},   {31'd0, got.err});
      chk("pcplus", bus.PC_PLUS, got.pc + 32'd4);
      chk("target", bus.TARGET,  m_tgt(got.pc, off));
    end
  endtask

  task automatic idle();
    step(1, 0, 0, 0, 0, 0, 8'h00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    m_pc = 32'h0; m_err = 1'b0;
    RESET = 1'b0; bus.STALL = 0; bus.BRANCH = 0; bus.JUMP = 0;
    bus.CALL = 0; bus.RET = 0; bus.OFFSET = '0;

    // reset state
    step(0, 0, 0, 0, 0, 0, 8'h00);
    chk("rst_pc", bus.PC, 32'h0);
    chk("rst_empty", {31'd0, bus.RAS_EMPTY}, 32'd1);
    chk("rst_err", {31'd0, bus.RAS_ERR}, 32'd0);

    // sequential
    for (int i = 1; i <= 3; i++) begin
      idle();
      chk("seq_pc", bus.PC, 32'(i * 4));
    end
    idle();                                   // 0x10

    // branches, backward then forward
    step(1, 0, 1, 0, 0, 0, 8'hFE);
    chk("br_back", bus.PC, 32'h0C);
    idle();                                   // 0x10
    step(1, 0, 1, 0, 0, 0, 8'h03);
    chk("br_fwd", bus.PC, 32'h20);

    // call / return
    step(1, 0, 0, 0, 1, 0, 8'h10);
    chk("call_pc", bus.PC, 32'h64);
    idle(); idle();
    step(1, 0, 0, 0, 0, 1, 8'h00);
    chk("ret_pc", bus.PC, 32'h24);
    chk("ret_empty", {31'd0, bus.RAS_EMPTY}, 32'd1);
    chk("ret_noerr", {31'd0, bus.RAS_ERR}, 32'd0);

    // underflow
    step(1, 0, 0, 1, 0, 0, 8'h06);
    chk("jmp_40", bus.PC, 32'h40);
    step(1, 0, 0, 0, 0, 1, 8'h00);
    chk("uflow_pc", bus.PC, 32'h44);
    chk("uflow_err", {31'd0, bus.RAS_ERR}, 32'd1);

    // overflow: five calls into a four-deep stack
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 1, 0, 8'h00);
    chk("oflow_full", {31'd0, bus.RAS_FULL}, 32'd1);
    chk("oflow_err", {31'd0, bus.RAS_ERR}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, 0, 0, 1, 8'h00);
      chk("oflow_ret", bus.PC, 32'h58 - 32'(i * 4));
    end
    chk("drain_empty", {31'd0, bus.RAS_EMPTY}, 32'd1);

    // stall overrides branch
    step(1, 1, 1, 0, 0, 0, 8'h10);
    step(1, 1, 1, 0, 0, 0, 8'h10);
    chk("stall_pc", bus.PC, 32'h4C);

    // CALL+RET with one entry: RET wins, no push
    step(1, 0, 0, 1, 0, 0, 8'h2B);
    chk("jmp_fc", bus.PC, 32'hFC);
    step(1, 0, 0, 0, 1, 0, 8'h00);
    chk("call_100", bus.PC, 32'h100);
    step(1, 0, 0, 0, 1, 1, 8'h08);
    chk("callret_pc", bus.PC, 32'h100);
    chk("callret_empty", {31'd0, bus.RAS_EMPTY}, 32'd1);

    // wrap
    step(1, 0, 0, 1, 0, 0, 8'hBE);
    chk("jmp_top", bus.PC, 32'hFFFF_FFFC);
    idle();
    chk("wrap_pc", bus.PC, 32'h0);

    // reset during CALL, after pushing an entry
    step(1, 0, 0, 0, 1, 0, 8'h04);
    step(0, 0, 0, 0, 1, 0, 8'h04);
    chk("rstcall_pc", bus.PC, 32'h0);
    chk("rstcall_empty", {31'd0, bus.RAS_EMPTY}, 32'd1);
    chk("rstcall_err", {31'd0, bus.RAS_ERR}, 32'd0);
    idle();
    chk("post_rst", bus.PC, 32'h4);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter unit for the single-cycle CPU. Replaces the standalone PC increment adder.
- Holds the PC register and computes the sequential PC, the PC-relative branch/jump target and the next-PC select.
- Adds a small return-address stack (RAS) for call/return.
- Sits between the control unit and the instruction memory.

Parameters:
- PC_W, 32, PC width in bits.
- INC, 4, sequential increment in bytes.
- OFF_W, 8, width of signed instruction offset field.
- OFF_SHIFT, 2, left shift applied to sign-extended offset (word to byte).
- RESET_PC, 0, PC value loaded on reset.
- RAS_DEPTH, 4, return-address stack entries (power of two, ≥2).

Ports:
- CLK  in  1  system clock, rising edge active.
- RESET  in  1  synchronous reset, active-low.
- STALL  in  1  hold PC and RAS this cycle.
- BRANCH  in  1  conditional branch taken (control unit already resolved condition).
- JUMP  in  1  unconditional PC-relative jump.
- CALL  in  1  PC-relative jump plus push of return address.
- RET  in  1  pop return address into PC.
- OFFSET  in  OFF_W  signed instruction offset.
- PC  out  PC_W  current PC (registered).
- PC_PLUS  out  PC_W  PC + INC (combinational from PC).
- TARGET  out  PC_W  PC_PLUS + (sext(OFFSET) << OFF_SHIFT) (combinational).
- RAS_EMPTY  out  1  stack holds 0 entries.
- RAS_FULL  out  1  stack holds RAS_DEPTH entries.
- RAS_ERR  out  1  sticky error flag: underflow or overflow occurred.

Behaviour:
- One clock. Reset is synchronous, active-low. Sampled on rising CLK while RESET==0.
- Reset values: PC=RESET_PC, RAS count=0, RAS_EMPTY=1, RAS_FULL=0, RAS_ERR=0. RAS storage contents are don't-care.
- Arithmetic: all sums are modulo 2^PC_W and wrap silently. OFFSET is sign-extended to PC_W before the shift.
- Next-PC priority, evaluated each rising edge:
  - !RESET: reset values.
  - STALL: PC held, RAS unchanged.
  - RET:
    - Not empty: PC=top entry, count-1.
    - Empty: PC=PC_PLUS, RAS_ERR<=1.
  - CALL:
    - PC=TARGET, push PC_PLUS, count+1.
    - Full: oldest entry overwritten (circular), count stays RAS_DEPTH, RAS_ERR<=1.
  - JUMP or BRANCH: PC=TARGET.
  - Otherwise: PC=PC_PLUS.
- Simultaneous requests resolve by the priority above. RET with CALL: RET wins, CALL ignored (no push).
- Latency: new PC visible one cycle after the request. PC_PLUS and TARGET follow PC combinationally with zero modelled delay.
- RAS_ERR clears only on reset.
- RAS_EMPTY and RAS_FULL are derived from the registered count.
- Reset mid-sequence (e.g. with CALL asserted) discards the request. The stack is emptied.

Decomposition:
- Shared package pc_pkg holds:
  - Localparam for next-PC select encoding (SEL_SEQ, SEL_TGT, SEL_RAS, SEL_HOLD).
  - Default widths PC_W/OFF_W.
- Sub-module pc_ras: circular stack with push/pop/full/empty/err and parameter RAS_DEPTH.
- pc_unit contains the PC register, adders and select logic.

Test Plan:
- Reset then 3 idle cycles with defaults: PC = 0, 4, 8, 12. PC_PLUS is always PC+4.
- Branch: at PC=0x10, BRANCH=1, OFFSET=8'hFE (−2) → next PC = 0x14 − 8 = 0x0C. OFFSET=8'h03 from PC=0x10 → 0x20.
- Call/return: CALL at PC=0x20, OFFSET=8'h10 → PC=0x64, RAS top=0x24. Two idle cycles, then RET → PC=0x24, RAS_EMPTY=1, RAS_ERR=0.
- Underflow and overflow:
  - RET on empty stack at PC=0x40 → PC=0x44, RAS_ERR=1 and stays 1.
  - Five CALLs with RAS_DEPTH=4 → RAS_FULL=1, RAS_ERR=1. Then four RETs return the four most recent return addresses.
- Stall and priority:
  - STALL=1 with BRANCH=1 for 2 cycles → PC unchanged.
  - CALL+RET together with one entry 0x100 → PC=0x100, no push.
- Wrap and reset:
  - PC=0xFFFFFFFC idle → PC=0x00000000.
  - RESET=0 asserted during CALL → PC=RESET_PC, RAS_EMPTY=1, RAS_ERR=0 next edge.
